// File: rtl/regfile_pkg.sv
// Shared sizing helpers and core defaults for the register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 16;

  function automatic int addrWidth(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve at issue, clear at writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W   = addrWidth(DEPTH),
  parameter int COUNT_W  = countWidth(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEnable,
  input  logic [ADDR_W-1:0]  writeAddr,
  input  logic               reserveEnable,
  input  logic [ADDR_W-1:0]  reserveAddr,
  output logic [DEPTH-1:0]   busy,
  output logic               reserveConflict,
  output logic [COUNT_W-1:0] busyCount
);

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic               wrLegal;
  logic               rsvLegal;
  logic [DEPTH-1:0]   busyNext;
  logic [COUNT_W-1:0] cntNext;

  assign wrLegal  = writeEnable && legal(writeAddr);
  assign rsvLegal = reserveEnable && legal(reserveAddr);

  // Reserve is applied last so a same-address reserve wins over the clear.
  always_comb begin
    busyNext = busy;
    if (wrLegal)
      busyNext[writeAddr] = 1'b0;
    if (rsvLegal)
      busyNext[reserveAddr] = 1'b1;
  end

  always_comb begin
    cntNext = '0;
    for (int i = 0; i < DEPTH; i++)
      cntNext = cntNext + COUNT_W'(busyNext[i]);
  end

  assign reserveConflict = rsvLegal && busy[reserveAddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      busyCount <= '0;
    end else begin
      busy      <= busyNext;
      busyCount <= cntNext;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with optional zero register, bypass and busy scoreboard.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = addrWidth(DEPTH),
  localparam int COUNT_W = countWidth(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     writeEnable,
  input  logic [ADDR_W-1:0]        writeAddr,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [NUM_RD*ADDR_W-1:0] readAddr,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic                     reserveEnable,
  input  logic [ADDR_W-1:0]        reserveAddr,
  output logic                     reserveConflict,
  output logic [COUNT_W-1:0]       busyCount
);

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wrLegal;

  assign wrLegal = writeEnable && legal(writeAddr);

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W),
    .COUNT_W  (COUNT_W)
  ) u_sb (
    .clk             (clk),
    .reset           (reset),
    .writeEnable     (writeEnable),
    .writeAddr       (writeAddr),
    .reserveEnable   (reserveEnable),
    .reserveAddr     (reserveAddr),
    .busy            (busy),
    .reserveConflict (reserveConflict),
    .busyCount       (busyCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wrLegal) begin
      regs[writeAddr] <= writeData;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ok;
    logic              hit;

    assign ra  = readAddr[p*ADDR_W +: ADDR_W];
    assign ok  = legal(ra);
    // Bypass only matches legal writes, so it never hits a dropped address.
    assign hit = (BYPASS != 0) && wrLegal && (writeAddr == ra);

    assign readData[p*DATA_W +: DATA_W] =
      !ok ? '0 : (hit ? writeData : regs[ra]);
    assign readBusy[p] = ok && !hit && busy[ra];
  end

endmodule
